// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: retires one multiplier bit per clock.
// Signed mode multiplies magnitudes and negates the product at the end.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       upper_sum;
    logic [WIDTH:0]       upper_next;

    // |x| of a two's-complement value; -2^(WIDTH-1) maps onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state_q != IDLE);
        done    = done_q;
        product = product_q;
    end

    // Datapath next-state; the upper add is WIDTH+1 bits so the carry survives the shift.
    always_comb begin
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        product_d  = product_q;
        done_d     = 1'b0;
        upper_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        upper_next = mplier_q[0] ? upper_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = signed_mode ? magnitude(a) : a;
                    mplier_d = signed_mode ? magnitude(b) : b;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                end
            end
            CALC: begin
                acc_d    = {upper_next, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
            end
            FIN: begin
                product_d = neg_q ? negate(acc_q) : acc_q;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed table at WIDTH=8, handshake corner cases,
// and randomized operations at WIDTH 2, 8 and 16 against an arithmetic model.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  sm_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [3:0]  p2;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [63:0] prod_v [3];

    int wid [3] = '{2, 8, 16};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_v[0]),
        .a(a_v[0][1:0]), .b(b_v[0][1:0]), .busy(busy_v[0]), .done(done_v[0]),
        .product(p2));
    seq_mult #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]),
        .product(p8));
    seq_mult #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_v[2]),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]), .busy(busy_v[2]), .done(done_v[2]),
        .product(p16));

    assign prod_v[0] = 64'(p2);
    assign prod_v[1] = 64'(p8);
    assign prod_v[2] = 64'(p16);

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    // Plain integer product of the operands as the mode interprets them, kept to 2*w bits.
    function automatic logic [63:0] ref_mult(int w, bit sm, logic [31:0] a, logic [31:0] b);
        logic [63:0] m;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        sa = longint'(64'(a) & m);
        sb = longint'(64'(b) & m);
        if (sm) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Start one operation on DUT k and wait (bounded) for done.
    // edges = clock edges from the sampling edge to the done edge; returns at the done cycle.
    task automatic do_op(input int k, input bit sm, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output int edges, output int busyc);
        @(negedge clk);
        sm_v[k]    = sm;
        a_v[k]     = a;
        b_v[k]     = b;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        edges = 0;
        busyc = 0;
        while (!done_v[k] && edges < 40) begin
            if (busy_v[k]) busyc++;
            @(negedge clk);
            edges++;
        end
        p = prod_v[k];
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] hold;
        int          e;
        int          bc;
        int          ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;

        vecs[0] = '{1'b0, 8'd7,   8'd5,   16'h0023};
        vecs[1] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        vecs[2] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[3] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
        vecs[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[5] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[6] = '{1'b1, 8'h00,  8'h80,  16'h0000};
        vecs[7] = '{1'b0, 8'h80,  8'h80,  16'h4000};
        vecs[8] = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
        vecs[9] = '{1'b0, 8'h80,  8'hFF,  16'h7F80};

        rst_n   = 1'b0;
        start_v = '0;
        sm_v    = '0;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy_w%0d", wid[i]), 64'(busy_v[i]), 64'd0);
            chk($sformatf("reset_done_w%0d", wid[i]), 64'(done_v[i]), 64'd0);
            chk($sformatf("reset_prod_w%0d", wid[i]), prod_v[i], 64'd0);
        end
        rst_n = 1'b1;

        // Directed table at WIDTH=8
        for (int i = 0; i < 10; i++) begin
            do_op(1, vecs[i].sm, 32'(vecs[i].a), 32'(vecs[i].b), p, e, bc);
            chk($sformatf("table%0d_prod", i), p, 64'(vecs[i].exp));
            chk($sformatf("table%0d_latency", i), 64'(e), 64'd9);
            chk($sformatf("table%0d_busy_cycles", i), 64'(bc), 64'd9);
        end

        // Product holds between operations
        hold = prod_v[1];
        repeat (5) @(negedge clk);
        chk("prod_hold", prod_v[1], hold);
        chk("done_single_pulse", 64'(done_v[1]), 64'd0);

        // Ignored start while busy, operand churn, then start on the done cycle
        @(negedge clk);
        sm_v[1] = 1'b0; a_v[1] = 32'd2; b_v[1] = 32'd3; start_v[1] = 1'b1;
        @(negedge clk);
        e = 0;
        while (!done_v[1] && e < 30) begin
            start_v[1] = (e == 3);
            a_v[1]     = (e == 3) ? 32'd9 : $urandom;
            b_v[1]     = 32'd9;
            sm_v[1]    = 1'($urandom);
            @(negedge clk);
            e++;
        end
        chk("busy_start_latency", 64'(e), 64'd9);
        chk("busy_start_prod", prod_v[1], 64'h6);
        sm_v[1] = 1'b0; a_v[1] = 32'd4; b_v[1] = 32'd4; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        e = 0;
        while (!done_v[1] && e < 30) begin
            @(negedge clk);
            e++;
        end
        chk("b2b_latency", 64'(e), 64'd9);
        chk("b2b_prod", prod_v[1], 64'h10);

        // Reset mid-operation
        @(negedge clk);
        a_v[1] = 32'd10; b_v[1] = 32'd10; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy_v[1]), 64'd0);
        chk("rst_mid_done", 64'(done_v[1]), 64'd0);
        chk("rst_mid_prod", prod_v[1], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[1]) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        do_op(1, 1'b0, 32'd10, 32'd10, p, e, bc);
        chk("rst_after_prod", p, 64'h64);
        chk("rst_after_latency", 64'(e), 64'd9);

        // Random regression per width, both modes mixed
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                rs = 1'($urandom);
                ra = $urandom & ((32'd1 << wid[k]) - 32'd1);
                rb = $urandom & ((32'd1 << wid[k]) - 32'd1);
                if (n % 50 == 0) ra = 32'd1 << (wid[k] - 1);
                do_op(k, rs, ra, rb, p, e, bc);
                chk($sformatf("rand_w%0d_s%0d_%0h_%0h", wid[k], rs, ra, rb), p,
                    ref_mult(wid[k], rs, ra, rb));
                chk($sformatf("rand_w%0d_latency", wid[k]), 64'(e), 64'(wid[k] + 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
